smachine_io_port: RTL and testbench

Memory-mapped switch/LED peripheral on the SMachine core's I/O bus; the board-facing end of the `switch0`/`switch1` → `led0`/`led1` path that the system bench drives and observes. It synchronises and debounces raw switch inputs, latches sticky rising-edge flags, and holds an LED output register written by the CPU. A single-outstanding req/ack handshake gives the core register access, and an optional level interrupt flags pending switch edges.

---
 rtl/smachine_pkg.sv | 20 ++
 rtl/smachine_io_port_if.sv | 26 ++
 rtl/smachine_debounce.sv | 60 ++++++
 rtl/smachine_io_port.sv | 128 ++++++++++++
 tb/tb_smachine_io_port.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smachine_pkg.sv
// rtl/smachine_pkg.sv - shared constants and types for the SMachine I/O port
//
// Purpose: register address map, bus data width and bus FSM state encoding
//          used by the switch/LED peripheral and its bench.
// Ports:   none (package).
package smachine_pkg;

  localparam int IO_DATA_W = 8;

  localparam logic [1:0] IO_ADDR_SW_STATE = 2'd0;
  localparam logic [1:0] IO_ADDR_SW_EDGE  = 2'd1;
  localparam logic [1:0] IO_ADDR_LED      = 2'd2;
  localparam logic [1:0] IO_ADDR_CTRL     = 2'd3;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/smachine_io_port_if.sv
// rtl/smachine_io_port_if.sv - req/ack register bus between core and I/O port
//
// Purpose: bundles the single-outstanding register access handshake.
// Signals: bus_req/bus_we/bus_addr/bus_wdata driven by the master (core),
//          bus_rdata/bus_ack driven by the slave (peripheral).
interface smachine_io_port_if;
  import smachine_pkg::*;

  logic                 bus_req;
  logic                 bus_we;
  logic [1:0]           bus_addr;
  logic [IO_DATA_W-1:0] bus_wdata;
  logic [IO_DATA_W-1:0] bus_rdata;
  logic                 bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/smachine_debounce.sv
// rtl/smachine_debounce.sv - one-bit switch synchroniser and debouncer
//
// Purpose: brings a raw asynchronous switch into the clk domain through two
//          flops, then accepts a level change only after DEBOUNCE_CYCLES
//          consecutive synchronised samples differ from the current level.
// Ports:   clk, reset  - clock, synchronous active-high reset
//          din_i       - raw switch input
//          stable_o    - debounced level
//          rise_o      - high in the cycle whose closing edge raises stable_o
module smachine_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q, sync2_q;
  logic [7:0] cnt_q, cnt_d;
  logic       stable_q, stable_d;
  logic       flip;

  // Flip when this sample completes a run of DB_LIMIT differing samples.
  assign flip = (sync2_q != stable_q) && ((cnt_q + 8'd1) == DB_LIMIT);

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = 8'd0;
    end else if (flip) begin
      cnt_d    = 8'd0;
      stable_d = ~stable_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= 8'd0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = flip & ~stable_q;

endmodule

// File: rtl/smachine_io_port.sv
// rtl/smachine_io_port.sv - memory-mapped switch/LED peripheral
//
// Purpose: debounced switch levels, sticky rising-edge flags, CPU-written LED
//          register and a level interrupt, reached over a req/ack bus.
// Ports:   clk, reset  - clock, synchronous active-high reset
//          bus         - register access handshake (slave side)
//          switch_in   - raw switch inputs, switch0 = bit 0
//          led_out     - LED drive, led0 = bit 0
//          irq         - irq_en AND any pending edge flag
module smachine_io_port #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_SW          = 2,
  parameter int NUM_LED         = 2
) (
  input  logic                clk,
  input  logic                reset,
  smachine_io_port_if.slave   bus,
  input  logic [NUM_SW-1:0]   switch_in,
  output logic [NUM_LED-1:0]  led_out,
  output logic                irq
);
  import smachine_pkg::*;

  // Bits at or above NUM_SW / NUM_LED are held at zero by these masks.
  localparam logic [IO_DATA_W-1:0] SW_MASK  = IO_DATA_W'((1 << NUM_SW) - 1);
  localparam logic [IO_DATA_W-1:0] LED_MASK = IO_DATA_W'((1 << NUM_LED) - 1);

  logic [NUM_SW-1:0]    sw_stable;
  logic [NUM_SW-1:0]    sw_rise;

  bus_state_e           state_q, state_d;
  logic [IO_DATA_W-1:0] led_q, led_d;
  logic [IO_DATA_W-1:0] edge_q, edge_d;
  logic [IO_DATA_W-1:0] rdata_q, rdata_d;
  logic                 irq_en_q, irq_en_d;
  logic [IO_DATA_W-1:0] rd_mux;
  logic [IO_DATA_W-1:0] edge_clr;
  logic                 accept;
  logic                 wr_en;
  logic                 rd_en;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    smachine_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .din_i    (switch_in[g]),
      .stable_o (sw_stable[g]),
      .rise_o   (sw_rise[g])
    );
  end

  // Bus FSM: a request is taken only in IDLE, so a held req yields one
  // access every two cycles.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (bus.bus_req) begin
          accept  = 1'b1;
          state_d = BUS_ACK;
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  assign wr_en = accept & bus.bus_we;
  assign rd_en = accept & ~bus.bus_we;

  // Read mux sees register values before this edge's updates.
  always_comb begin
    rd_mux = '0;
    case (bus.bus_addr)
      IO_ADDR_SW_STATE: rd_mux = IO_DATA_W'(sw_stable);
      IO_ADDR_SW_EDGE:  rd_mux = edge_q;
      IO_ADDR_LED:      rd_mux = led_q;
      IO_ADDR_CTRL:     rd_mux = {{(IO_DATA_W-1){1'b0}}, irq_en_q};
      default:          rd_mux = '0;
    endcase
  end

  always_comb begin
    led_d    = led_q;
    irq_en_d = irq_en_q;
    edge_clr = '0;
    rdata_d  = rdata_q;
    if (wr_en && (bus.bus_addr == IO_ADDR_LED)) begin
      led_d = bus.bus_wdata & LED_MASK;
    end
    if (wr_en && (bus.bus_addr == IO_ADDR_CTRL)) begin
      irq_en_d = bus.bus_wdata[0];
    end
    if (wr_en && (bus.bus_addr == IO_ADDR_SW_EDGE)) begin
      edge_clr = bus.bus_wdata;
    end
    if (rd_en) begin
      rdata_d = rd_mux;
    end
    // New rises are ORed in after the clear so a coincident set survives.
    edge_d = ((edge_q & ~edge_clr) | IO_DATA_W'(sw_rise)) & SW_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BUS_IDLE;
      led_q    <= '0;
      edge_q   <= '0;
      rdata_q  <= '0;
      irq_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      edge_q   <= edge_d;
      rdata_q  <= rdata_d;
      irq_en_q <= irq_en_d;
    end
  end

  assign bus.bus_ack   = (state_q == BUS_ACK);
  assign bus.bus_rdata = rdata_q;
  assign led_out       = led_q[NUM_LED-1:0];
  assign irq           = irq_en_q & (|edge_q);

endmodule

// File: tb/tb_smachine_io_port.sv
// tb/tb_smachine_io_port.sv - self-checking bench for smachine_io_port
module tb_smachine_io_port;

  localparam int DC = 4;

  logic       clk;
  logic       reset;
  logic [1:0] switch_in;
  logic [1:0] led_out;
  logic       irq;

  int total = 0;
  int bad   = 0;

  // Behavioural expectations for the randomized scenario.
  logic [1:0] m_in, m_state, m_edge, m_led;
  logic       m_irq_en;

  smachine_io_port_if bif ();

  smachine_io_port #(
    .DEBOUNCE_CYCLES(DC),
    .NUM_SW(2),
    .NUM_LED(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .switch_in (switch_in),
    .led_out   (led_out),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus access; lat = negedges from request to ack seen (-1 on timeout).
  task automatic bus_access(input logic we, input logic [1:0] addr,
                            input logic [7:0] wd, output logic [7:0] rd,
                            output int lat);
    @(negedge clk);
    bif.bus_req   = 1'b1;
    bif.bus_we    = we;
    bif.bus_addr  = addr;
    bif.bus_wdata = wd;
    lat = -1;
    rd  = 8'hxx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bif.bus_ack === 1'b1) begin
        lat = i;
        rd  = bif.bus_rdata;
        break;
      end
    end
    bif.bus_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    int lat;
    total++; if (bif.bus_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", bif.bus_ack); end
    total++; if (bif.bus_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", bif.bus_rdata); end
    total++; if (led_out !== 2'b00) begin bad++; $display("FAIL rst_led got=%b want=00", led_out); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
    bus_access(1'b0, 2'd0, 8'h00, rd, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL rst_rd_latency got=%0d want=1", lat); end
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL rst_rd_sw_state got=%h want=00", rd); end
  endtask

  task automatic test_led();
    logic [7:0] rd;
    int lat;
    bus_access(1'b1, 2'd2, 8'h03, rd, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL led_wr_latency got=%0d want=1", lat); end
    total++; if (led_out !== 2'b11) begin bad++; $display("FAIL led_out got=%b want=11", led_out); end
    bus_access(1'b0, 2'd2, 8'h00, rd, lat);
    total++; if (rd !== 8'h03) begin bad++; $display("FAIL led_readback got=%h want=03", rd); end
    bus_access(1'b1, 2'd0, 8'hFF, rd, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL ro_wr_latency got=%0d want=1", lat); end
    bus_access(1'b0, 2'd0, 8'h00, rd, lat);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL ro_sw_state got=%h want=00", rd); end
    bus_access(1'b1, 2'd2, 8'hFE, rd, lat);
    bus_access(1'b0, 2'd2, 8'h00, rd, lat);
    total++; if (rd !== 8'h02) begin bad++; $display("FAIL led_upper_ignored got=%h want=02", rd); end
    total++; if (led_out !== 2'b10) begin bad++; $display("FAIL led_out2 got=%b want=10", led_out); end
  endtask

  task automatic test_debounce();
    logic [7:0] rd;
    int lat;
    logic seen;
    bus_access(1'b1, 2'd3, 8'h01, rd, lat);
    // Glitch held for DC-1 samples must vanish.
    @(negedge clk);
    switch_in[0] = 1'b1;
    repeat (DC - 1) @(negedge clk);
    switch_in[0] = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | irq;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL glitch_irq got=%b want=0", seen); end
    bus_access(1'b0, 2'd0, 8'h00, rd, lat);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL glitch_state got=%h want=00", rd); end
    bus_access(1'b0, 2'd1, 8'h00, rd, lat);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL glitch_edge got=%h want=00", rd); end
    // Held level: appears 2+DC edges after the first sampling edge.
    @(negedge clk);
    switch_in[0] = 1'b1;
    repeat (DC + 1) @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL deb_early got=%b want=0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL deb_on_time got=%b want=1", irq); end
    bus_access(1'b0, 2'd0, 8'h00, rd, lat);
    total++; if (rd !== 8'h01) begin bad++; $display("FAIL deb_state got=%h want=01", rd); end
    bus_access(1'b0, 2'd1, 8'h00, rd, lat);
    total++; if (rd !== 8'h01) begin bad++; $display("FAIL deb_edge got=%h want=01", rd); end
    bus_access(1'b1, 2'd1, 8'h01, rd, lat);
    bus_access(1'b0, 2'd1, 8'h00, rd, lat);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL deb_w1c got=%h want=00", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL deb_irq_clr got=%b want=0", irq); end
  endtask

  task automatic test_irq();
    logic [7:0] rd;
    int lat;
    @(negedge clk);
    switch_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    bus_access(1'b0, 2'd1, 8'h00, rd, lat);
    total++; if (rd !== 8'h02) begin bad++; $display("FAIL irq_edge got=%h want=02", rd); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b want=1", irq); end
    bus_access(1'b1, 2'd1, 8'h02, rd, lat);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b want=0", irq); end
    bus_access(1'b0, 2'd1, 8'h00, rd, lat);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL irq_edge_clr got=%h want=00", rd); end
  endtask

  task automatic test_set_wins();
    logic [7:0] rd;
    int lat;
    @(negedge clk);
    switch_in[0] = 1'b0;
    repeat (12) @(negedge clk);
    switch_in[0] = 1'b1;
    // Five sampling edges pass; the sixth edge raises stable and takes the W1C.
    repeat (DC + 1) @(posedge clk);
    @(negedge clk);
    bif.bus_req   = 1'b1;
    bif.bus_we    = 1'b1;
    bif.bus_addr  = 2'd1;
    bif.bus_wdata = 8'h01;
    @(negedge clk);
    total++; if (bif.bus_ack !== 1'b1) begin bad++; $display("FAIL setwins_ack got=%b want=1", bif.bus_ack); end
    bif.bus_req = 1'b0;
    bus_access(1'b0, 2'd1, 8'h00, rd, lat);
    total++; if (rd !== 8'h01) begin bad++; $display("FAIL setwins_edge got=%h want=01", rd); end
    bus_access(1'b1, 2'd1, 8'hFF, rd, lat);
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    int lat;
    int acks;
    logic rd_ok;
    bus_access(1'b1, 2'd2, 8'h01, rd, lat);
    @(negedge clk);
    bif.bus_req  = 1'b1;
    bif.bus_we   = 1'b0;
    bif.bus_addr = 2'd2;
    acks  = 0;
    rd_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bif.bus_ack === 1'b1) begin
        acks++;
        if (bif.bus_rdata !== 8'h01) rd_ok = 1'b0;
      end
    end
    bif.bus_req = 1'b0;
    total++; if (acks !== 2) begin bad++; $display("FAIL b2b_acks got=%0d want=2", acks); end
    total++; if (rd_ok !== 1'b1) begin bad++; $display("FAIL b2b_rdata got=%b want=1", rd_ok); end
  endtask

  task automatic test_random();
    logic [7:0] rd;
    int lat;
    logic [1:0] v, w, c;
    int len;
    bus_access(1'b1, 2'd2, 8'h00, rd, lat);
    bus_access(1'b1, 2'd3, 8'h00, rd, lat);
    bus_access(1'b1, 2'd1, 8'hFF, rd, lat);
    m_led    = 2'b00;
    m_irq_en = 1'b0;
    m_edge   = 2'b00;
    m_in     = switch_in;
    m_state  = switch_in;
    for (int it = 0; it < 12; it++) begin
      // Pulse away from the held level for len samples, then return.
      v   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 7);
      @(negedge clk);
      switch_in = v;
      repeat (len) @(negedge clk);
      switch_in = m_in;
      repeat (12) @(negedge clk);
      if (len >= DC) m_edge = m_edge | (v ^ m_in);
      // Move to a new held level.
      w = 2'($urandom_range(0, 3));
      switch_in = w;
      repeat (12) @(negedge clk);
      m_edge  = m_edge | (w & ~m_state);
      m_state = w;
      m_in    = w;
      m_irq_en = 1'($urandom_range(0, 1));
      bus_access(1'b1, 2'd3, {7'h00, m_irq_en} | 8'($urandom_range(0, 127) << 1), rd, lat);
      total++; if (irq !== (m_irq_en & (|m_edge))) begin bad++; $display("FAIL rnd_irq it=%0d got=%b want=%b", it, irq, m_irq_en & (|m_edge)); end
      bus_access(1'b0, 2'd0, 8'h00, rd, lat);
      total++; if (rd !== {6'h00, m_state}) begin bad++; $display("FAIL rnd_state it=%0d got=%h want=%h", it, rd, {6'h00, m_state}); end
      bus_access(1'b0, 2'd1, 8'h00, rd, lat);
      total++; if (rd !== {6'h00, m_edge}) begin bad++; $display("FAIL rnd_edge it=%0d got=%h want=%h", it, rd, {6'h00, m_edge}); end
      bus_access(1'b0, 2'd3, 8'h00, rd, lat);
      total++; if (rd !== {7'h00, m_irq_en}) begin bad++; $display("FAIL rnd_ctrl it=%0d got=%h want=%h", it, rd, {7'h00, m_irq_en}); end
      c = 2'($urandom_range(0, 3));
      bus_access(1'b1, 2'd1, {6'h00, c}, rd, lat);
      m_edge = m_edge & ~c;
      bus_access(1'b0, 2'd1, 8'h00, rd, lat);
      total++; if (rd !== {6'h00, m_edge}) begin bad++; $display("FAIL rnd_w1c it=%0d got=%h want=%h", it, rd, {6'h00, m_edge}); end
      rd = 8'($urandom_range(0, 255));
      m_led = rd[1:0];
      bus_access(1'b1, 2'd2, rd, rd, lat);
      total++; if (led_out !== m_led) begin bad++; $display("FAIL rnd_led it=%0d got=%b want=%b", it, led_out, m_led); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    int lat;
    logic seen_ack;
    @(negedge clk);
    switch_in = 2'b00;
    repeat (12) @(negedge clk);
    bus_access(1'b1, 2'd2, 8'h01, rd, lat);
    bus_access(1'b1, 2'd3, 8'h01, rd, lat);
    // Reset during ACK.
    @(negedge clk);
    bif.bus_req   = 1'b1;
    bif.bus_we    = 1'b1;
    bif.bus_addr  = 2'd2;
    bif.bus_wdata = 8'h02;
    @(negedge clk);
    total++; if (bif.bus_ack !== 1'b1) begin bad++; $display("FAIL rmid_ack_before got=%b want=1", bif.bus_ack); end
    bif.bus_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++; if (bif.bus_ack !== 1'b0) begin bad++; $display("FAIL rmid_ack_after got=%b want=0", bif.bus_ack); end
    total++; if (led_out !== 2'b00) begin bad++; $display("FAIL rmid_led got=%b want=00", led_out); end
    total++; if (bif.bus_rdata !== 8'h00) begin bad++; $display("FAIL rmid_rdata got=%h want=00", bif.bus_rdata); end
    // Request presented while reset is high is dropped.
    bif.bus_req   = 1'b1;
    bif.bus_we    = 1'b1;
    bif.bus_addr  = 2'd2;
    bif.bus_wdata = 8'h03;
    @(negedge clk);
    bif.bus_req = 1'b0;
    reset = 1'b0;
    seen_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_ack = seen_ack | bif.bus_ack;
    end
    total++; if (seen_ack !== 1'b0) begin bad++; $display("FAIL rmid_no_ack got=%b want=0", seen_ack); end
    total++; if (led_out !== 2'b00) begin bad++; $display("FAIL rmid_no_write got=%b want=00", led_out); end
    for (int a = 0; a < 4; a++) begin
      bus_access(1'b0, 2'(a), 8'h00, rd, lat);
      total++; if (rd !== 8'h00) begin bad++; $display("FAIL rmid_reg%0d got=%h want=00", a, rd); end
    end
  endtask

  initial begin
    reset         = 1'b1;
    switch_in     = 2'b00;
    bif.bus_req   = 1'b0;
    bif.bus_we    = 1'b0;
    bif.bus_addr  = 2'd0;
    bif.bus_wdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_led();
    test_debounce();
    test_irq();
    test_set_wins();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
